// File: rtl/fsqrt_arbiter_if.sv
// Requester/core-facing bundle for the shared fsqrt arbiter.
// Lane i of every per-requester bus occupies bits [32i+31:32i].
interface fsqrt_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_x;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ-1:0][31:0] rsp_y;
  logic [31:0]           sq_x;
  logic [31:0]           sq_y;
  logic                  busy;

  // arbiter side
  modport slave (
    input  req_valid, req_x, rsp_ready, sq_y,
    output req_ready, rsp_valid, rsp_y, sq_x, busy
  );

  // requesters plus the shared core
  modport master (
    output req_valid, req_x, rsp_ready, sq_y,
    input  req_ready, rsp_valid, rsp_y, sq_x, busy
  );
endinterface

// File: rtl/fsqrt_arbiter.sv
// Round-robin sharing of one fixed-latency fsqrt core among NREQ requesters.
// Per-requester credits cap in-flight + queued results at FDEPTH, so every
// returning result always finds a free slot in its result FIFO.

// One requester's credit counter and FWFT result FIFO.
module fsqrt_arb_lane #(
  parameter int FDEPTH = 4,
  parameter int CW     = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue,
  input  logic        push,
  input  logic [31:0] push_y,
  input  logic        pop_rdy,
  output logic        credit_ok,
  output logic        rsp_valid,
  output logic [31:0] rsp_y
);
  localparam int AW = $clog2(FDEPTH);

  logic [31:0]   mem [FDEPTH];
  logic [AW:0]   wp, rp;
  logic [CW-1:0] outst;
  logic          pop;

  assign rsp_valid = (wp != rp);
  assign pop       = rsp_valid & pop_rdy;
  assign rsp_y     = rsp_valid ? mem[rp[AW-1:0]] : 32'h0;
  assign credit_ok = (outst < CW'(FDEPTH));

  // FIFO pointers; the extra MSB tells full from empty
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // result storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= push_y;
  end

  // outstanding = queued + in flight; issue and pop together cancel out
  always_ff @(posedge clk) begin
    if (!rstn) outst <= '0;
    else begin
      case ({issue, pop})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end
endmodule

module fsqrt_arbiter #(
  parameter int NREQ   = 2,
  parameter int LAT    = 2,
  parameter int FDEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  fsqrt_arbiter_if.slave  bus
);
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(FDEPTH + 1);

  logic [TW-1:0]         ptr;
  logic [NREQ-1:0]       credit_ok, elig, gnt, push;
  logic [NREQ-1:0]       rsp_vld;
  logic [NREQ-1:0][31:0] rsp_dat;
  logic                  iss_vld;
  logic [TW-1:0]         iss_tag;
  logic [LAT:1]          vld_pipe;
  logic [LAT:1][TW-1:0]  tag_pipe;
  int                    idx;

  // nothing is eligible while reset is held, so req_ready stays low
  assign elig = bus.req_valid & credit_ok & {NREQ{rstn}};

  // first eligible requester at or after the pointer, wrapping
  always_comb begin
    iss_vld = 1'b0;
    iss_tag = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!iss_vld && elig[idx]) begin
        iss_vld = 1'b1;
        iss_tag = TW'(idx);
      end
    end
  end

  // one-hot ready to the winner and its operand onto the core
  always_comb begin
    gnt      = '0;
    bus.sq_x = 32'h0;
    if (iss_vld) begin
      gnt[iss_tag] = 1'b1;
      bus.sq_x     = bus.req_x[iss_tag];
    end
  end

  assign bus.req_ready = gnt;

  // pointer moves past the winner; holds on idle cycles
  always_ff @(posedge clk) begin
    if (!rstn) ptr <= '0;
    else if (iss_vld) ptr <= (iss_tag == TW'(NREQ - 1)) ? '0 : iss_tag + 1'b1;
  end

  // tag tracker mirrors the core pipeline; reset drops in-flight results
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[1] <= iss_vld;
      tag_pipe[1] <= iss_tag;
      for (int s = 2; s <= LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign push[i] = vld_pipe[LAT] && (tag_pipe[LAT] == TW'(i));

    fsqrt_arb_lane #(.FDEPTH(FDEPTH), .CW(CW)) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .issue     (gnt[i]),
      .push      (push[i]),
      .push_y    (bus.sq_y),
      .pop_rdy   (bus.rsp_ready[i]),
      .credit_ok (credit_ok[i]),
      .rsp_valid (rsp_vld[i]),
      .rsp_y     (rsp_dat[i])
    );
  end

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_y     = rsp_dat;
  assign bus.busy      = (|vld_pipe) | (|rsp_vld);
endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Directed bench for fsqrt_arbiter (NREQ=2, LAT=2, FDEPTH=4) with a
// stand-in fsqrt core and per-requester expected-result queues.
module tb_fsqrt_arbiter;
  localparam int NREQ = 2, LAT = 2, FDEPTH = 4;

  logic clk, rstn;
  fsqrt_arbiter_if #(.NREQ(NREQ)) bus();

  fsqrt_arbiter #(.NREQ(NREQ), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [31:0] x0, x1;
  logic [31:0] q0[$], q1[$];

  // stand-in core: a few real square roots, pass-through specials, fake rest
  function automatic logic [31:0] f(input logic [31:0] x);
    case (x)
      32'h40800000: f = 32'h40000000;
      32'h41800000: f = 32'h40800000;
      32'h41100000: f = 32'h40400000;
      32'h3f800000: f = 32'h3f800000;
      32'h00000000: f = 32'h00000000;
      32'h80000000: f = 32'h80000000;
      32'h7f800000: f = 32'h7f800000;
      32'hbf800000: f = 32'h7fc00000;
      default:      f = x ^ 32'h00ffff00;
    endcase
  endfunction

  // core pipeline; garbage on bubbles so a stray push shows up
  logic [31:0] cp0, cp1;
  logic        cv0, cv1;
  always @(posedge clk) begin
    cp0 <= bus.sq_x;
    cv0 <= |(bus.req_valid & bus.req_ready);
    cp1 <= cp0;
    cv1 <= cv0;
  end
  assign bus.sq_y = cv1 ? f(cp1) : 32'hdeadbeef;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] rr);
    x0 = a;
    x1 = b;
    bus.req_valid = v;
    bus.req_x[0]  = a;
    bus.req_x[1]  = b;
    bus.rsp_ready = rr;
  endtask

  // head-of-FIFO data and order against the expected queues
  task automatic mon();
    if (bus.rsp_valid[0]) begin
      if (q0.size() == 0) chk("rsp0_spurious", bus.rsp_valid[0], 1'b0);
      else begin
        chk("rsp0_y", bus.rsp_y[0], q0[0]);
        if (bus.rsp_ready[0]) void'(q0.pop_front());
      end
    end
    if (bus.rsp_valid[1]) begin
      if (q1.size() == 0) chk("rsp1_spurious", bus.rsp_valid[1], 1'b0);
      else begin
        chk("rsp1_y", bus.rsp_y[1], q1[0]);
        if (bus.rsp_ready[1]) void'(q1.pop_front());
      end
    end
  endtask

  // one cycle: check grant/operand (and optionally busy/rsp_valid), then clock
  task automatic cyc(input string tag, input logic [1:0] exp_rdy, input int exp_busy,
                     input int exp_rv);
    logic [31:0] ex;
    #1;
    ex = exp_rdy[0] ? x0 : (exp_rdy[1] ? x1 : 32'h0);
    chk({tag, ".rdy"}, bus.req_ready, exp_rdy);
    chk({tag, ".sq_x"}, bus.sq_x, ex);
    if (exp_busy >= 0) chk({tag, ".busy"}, bus.busy, exp_busy[0]);
    if (exp_rv >= 0) chk({tag, ".rv"}, bus.rsp_valid, exp_rv[1:0]);
    if (rstn) mon();
    if (exp_rdy[0]) q0.push_back(f(x0));
    if (exp_rdy[1]) q1.push_back(f(x1));
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rr_a [8] = '{32'h40800000, 32'h00000000, 32'h41100000, 32'h80000000,
                            32'h3f800000, 32'h7f800000, 32'h41800000, 32'hbf800000};
  logic [31:0] rr_b [8] = '{32'h41800000, 32'h3f800000, 32'h00000000, 32'h41100000,
                            32'h7f800000, 32'hbf800000, 32'h40800000, 32'h80000000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset with requests pending: nothing may be granted
    rstn = 1'b0;
    drive(2'b11, 32'h41800000, 32'h41100000, 2'b00);
    repeat (2) cyc("rst", 2'b00, -1, -1);
    rstn = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 2'b00);
    #1;
    chk("rst.rv", bus.rsp_valid, 2'b00);
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.y0", bus.rsp_y[0], 32'h0);
    chk("rst.y1", bus.rsp_y[1], 32'h0);

    // single op: accept in 0, busy 1..3, rsp_valid in 3
    drive(2'b01, 32'h40800000, 32'h0, 2'b00);
    cyc("single0", 2'b01, 0, 0);
    drive(2'b00, 32'h0, 32'h0, 2'b00);
    cyc("single1", 2'b00, 1, 0);
    cyc("single2", 2'b00, 1, 0);
    drive(2'b00, 32'h0, 32'h0, 2'b01);
    cyc("single3", 2'b00, 1, 1);
    drive(2'b00, 32'h0, 32'h0, 2'b00);
    cyc("single4", 2'b00, 0, 0);
    chk("single.q0", q0.size(), 0);

    // idle: pointer sits at 1
    repeat (3) cyc("idle", 2'b00, 0, 0);

    // round robin, starting from requester 1, no gaps
    for (int k = 0; k < 8; k++) begin
      drive(2'b11, rr_a[k], rr_b[k], 2'b11);
      cyc("rr", (k % 2 == 0) ? 2'b10 : 2'b01, -1, -1);
    end
    drive(2'b00, 32'h0, 32'h0, 2'b11);
    repeat (4) cyc("rr_drain", 2'b00, -1, -1);
    cyc("rr_idle", 2'b00, 0, 0);
    chk("rr.q0", q0.size(), 0);
    chk("rr.q1", q1.size(), 0);

    // credit stall on requester 0
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 32'h42000000 + k, 32'h0, 2'b10);
      cyc("cr_acc", 2'b01, -1, -1);
    end
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, 32'h42000010 + k, 32'h0, 2'b10);
      cyc("cr_stall", 2'b00, -1, -1);
    end
    drive(2'b11, 32'h42000020, 32'h43000000, 2'b10);
    cyc("cr_other", 2'b10, -1, -1);
    drive(2'b01, 32'h42000021, 32'h0, 2'b11);
    cyc("cr_pop", 2'b00, -1, 2'b01);
    drive(2'b01, 32'h42000022, 32'h0, 2'b10);
    cyc("cr_one", 2'b01, -1, -1);
    drive(2'b01, 32'h42000023, 32'h0, 2'b10);
    cyc("cr_full", 2'b00, -1, -1);
    // pop while the last accepted result is pushed
    drive(2'b01, 32'h42000024, 32'h0, 2'b11);
    cyc("pp_same", 2'b00, -1, 2'b01);
    drive(2'b01, 32'h42000030, 32'h0, 2'b10);
    cyc("pp_after", 2'b01, -1, -1);
    drive(2'b01, 32'h42000031, 32'h0, 2'b10);
    cyc("pp_full", 2'b00, -1, -1);
    drive(2'b00, 32'h0, 32'h0, 2'b11);
    repeat (8) cyc("cr_drain", 2'b00, -1, -1);
    cyc("cr_idle", 2'b00, 0, 0);
    chk("cr.q0", q0.size(), 0);
    chk("cr.q1", q1.size(), 0);

    // reset mid-flight: two ops issued, reset the cycle after the second
    drive(2'b11, 32'h40800000, 32'h41800000, 2'b00);
    cyc("mf0", 2'b10, -1, -1);
    cyc("mf1", 2'b01, -1, -1);
    rstn = 1'b0;
    cyc("mf_rst", 2'b00, -1, -1);
    rstn = 1'b1;
    q0.delete();
    q1.delete();
    drive(2'b00, 32'h0, 32'h0, 2'b11);
    repeat (4) cyc("mf_after", 2'b00, 0, 0);
    drive(2'b11, 32'h41100000, 32'h3f800000, 2'b11);
    cyc("mf_new0", 2'b01, 0, 0);
    drive(2'b10, 32'h0, 32'hbf800000, 2'b11);
    cyc("mf_new1", 2'b10, 1, 0);
    drive(2'b00, 32'h0, 32'h0, 2'b11);
    repeat (4) cyc("mf_drain", 2'b00, -1, -1);
    cyc("mf_idle", 2'b00, 0, 0);
    chk("mf.q0", q0.size(), 0);
    chk("mf.q1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
